// File: rtl/line_scanout.sv
// rtl/line_scanout.sv - fetches one stored line per request and serialises it as a pixel stream with blanking and sync
module line_scanout #(
  parameter int PIXELS_PER_LINE = 330,
  parameter int LINES_PER_FRAME = 110,
  parameter int H_BLANK         = 16,
  parameter int HSYNC_W         = 4,
  parameter int V_BLANK         = 64,
  parameter int VSYNC_W         = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [0:8*PIXELS_PER_LINE-1]  FrameDataIn,
  output logic                          readFrame,
  output logic [9:0]                    readLineOutCounter,
  output logic [7:0]                    PxData,
  output logic                          PxValid,
  output logic [9:0]                    PxOut,
  output logic [9:0]                    LineOut,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          frameDone
);

  localparam int LW = 8 * PIXELS_PER_LINE;

  // Terminal counter values; each counter stops here and never wraps.
  localparam logic [9:0] PX_LAST   = 10'(PIXELS_PER_LINE - 1);
  localparam logic [9:0] LINE_LAST = 10'(LINES_PER_FRAME - 1);
  localparam logic [9:0] HB_LAST   = 10'(H_BLANK - 1);
  localparam logic [9:0] VB_LAST   = 10'(V_BLANK - 1);
  localparam logic [9:0] HSYNC_END = 10'(HSYNC_W);
  localparam logic [9:0] VSYNC_END = 10'(VSYNC_W);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_ACTIVE, S_HBLANK, S_VBLANK
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      line_q, line_d;
  logic [9:0]      pixel_q, pixel_d;
  logic [9:0]      blank_q, blank_d;
  logic [0:LW-1]   shift_q, shift_d;

  logic            read_q, read_d;
  logic [9:0]      rline_q, rline_d;
  logic [7:0]      pxdata_q, pxdata_d;
  logic            pxvalid_q, pxvalid_d;
  logic [9:0]      pxout_q, pxout_d;
  logic [9:0]      lineout_q, lineout_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            done_q, done_d;

  // Next-state sequencing: line fetch, pixel shift-out, then horizontal or vertical blanking.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    pixel_d = pixel_q;
    blank_d = blank_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_REQ;
          line_d  = '0;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        // The frame buffer presented the requested line at the edge that ended REQ.
        state_d = S_ACTIVE;
        pixel_d = '0;
        shift_d = FrameDataIn;
      end
      S_ACTIVE: begin
        if (pixel_q == PX_LAST) begin
          state_d = S_HBLANK;
          blank_d = '0;
        end else begin
          pixel_d = pixel_q + 10'd1;
          shift_d = shift_q << 8;
        end
      end
      S_HBLANK: begin
        if (blank_q == HB_LAST) begin
          blank_d = '0;
          if (line_q == LINE_LAST) begin
            state_d = S_VBLANK;
          end else begin
            state_d = S_REQ;
            line_d  = line_q + 10'd1;
          end
        end else begin
          blank_d = blank_q + 10'd1;
        end
      end
      S_VBLANK: begin
        if (blank_q == VB_LAST) begin
          blank_d = '0;
          line_d  = '0;
          state_d = enable ? S_REQ : S_IDLE;
        end else begin
          blank_d = blank_q + 10'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every port comes straight from a flop.
  always_comb begin
    read_d    = (state_d == S_REQ);
    rline_d   = (state_d == S_REQ) ? line_d : '0;
    pxvalid_d = (state_d == S_ACTIVE);
    pxdata_d  = (state_d == S_ACTIVE) ? shift_d[0:7] : '0;
    pxout_d   = (state_d == S_ACTIVE) ? pixel_d : '0;
    lineout_d = (state_d == S_ACTIVE) ? line_d : '0;
    hsync_d   = (state_d == S_HBLANK) && (blank_d < HSYNC_END);
    vsync_d   = (state_d == S_VBLANK) && (blank_d < VSYNC_END);
    done_d    = (state_d == S_VBLANK) && (blank_d == VB_LAST);
  end

  // State, counters, line shift register and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      line_q    <= '0;
      pixel_q   <= '0;
      blank_q   <= '0;
      shift_q   <= '0;
      read_q    <= 1'b0;
      rline_q   <= '0;
      pxdata_q  <= '0;
      pxvalid_q <= 1'b0;
      pxout_q   <= '0;
      lineout_q <= '0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      pixel_q   <= pixel_d;
      blank_q   <= blank_d;
      shift_q   <= shift_d;
      read_q    <= read_d;
      rline_q   <= rline_d;
      pxdata_q  <= pxdata_d;
      pxvalid_q <= pxvalid_d;
      pxout_q   <= pxout_d;
      lineout_q <= lineout_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      done_q    <= done_d;
    end
  end

  assign readFrame          = read_q;
  assign readLineOutCounter = rline_q;
  assign PxData             = pxdata_q;
  assign PxValid            = pxvalid_q;
  assign PxOut              = pxout_q;
  assign LineOut            = lineout_q;
  assign hsync              = hsync_q;
  assign vsync              = vsync_q;
  assign frameDone          = done_q;

endmodule
